// File: rtl/karatsuba_product_divider.sv
// karatsuba_product_divider: sequential restoring divider closing the loop on the Karatsuba
//   multiplier; 2N-bit dividend / N-bit divisor -> 2N-bit quotient, N-bit remainder.
// Latency: out_valid rises 2N cycles after the accepting edge (1 cycle for divide-by-zero).
// Backpressure: result held in DONE until out_ready; in_ready low while BUSY/DONE,
//   one operation per 2N+2 cycles.
// Ports: clk, rst_n (sync, active-low) | in_valid/in_ready, dividend[2N], divisor[N] |
//   out_valid/out_ready, quotient[2N], remainder[N], div_zero.
// Optional: define KARDIV_CHECK_EN to add chk_factor[N] (in) and mismatch (out), which
//   flag a result that is not exactly {0,chk_factor} with zero remainder.
module karatsuba_product_divider #(
  parameter int N = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [2*N-1:0] dividend,
  input  logic [N-1:0]   divisor,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] quotient,
  output logic [N-1:0]   remainder,
  output logic           div_zero
`ifdef KARDIV_CHECK_EN
  ,
  input  logic [N-1:0]   chk_factor,
  output logic           mismatch
`endif
);

  localparam int CW = $clog2(2*N+1);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t         r_state;
  logic [2*N-1:0] r_work;   // dividend shifts out the top, quotient bits shift in the bottom
  logic [N-1:0]   r_rem;
  logic [N-1:0]   r_dvs;
  logic [CW-1:0]  r_cnt;
  logic           r_dz;

  logic [N:0]     w_t;
  logic           w_ge;
  logic [N-1:0]   w_diff;

  // Partial remainder with the next dividend bit appended; one extra bit so the
  // compare never overflows.
  assign w_t  = {r_rem, r_work[2*N-1]};
  assign w_ge = (w_t >= {1'b0, r_dvs});
  // When w_ge holds the true difference is below the divisor, so the low N bits
  // of a modulo-2^N subtraction are exact.
  assign w_diff = w_t[N-1:0] - r_dvs;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_work  <= '0;
      r_rem   <= '0;
      r_dvs   <= '0;
      r_cnt   <= '0;
      r_dz    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_dvs   <= divisor;
            r_state <= S_BUSY;
            if (divisor == '0) begin
              // Saturated result is loaded now; one idle BUSY cycle gives the
              // single-cycle divide-by-zero latency.
              r_work <= '1;
              r_rem  <= '1;
              r_dz   <= 1'b1;
              r_cnt  <= CW'(1);
            end else begin
              r_work <= dividend;
              r_rem  <= '0;
              r_dz   <= 1'b0;
              r_cnt  <= CW'(2*N);
            end
          end
        end
        S_BUSY: begin
          if (!r_dz) begin
            r_work <= {r_work[2*N-2:0], w_ge};
            r_rem  <= w_ge ? w_diff : w_t[N-1:0];
          end
          r_cnt <= r_cnt - CW'(1);
          if (r_cnt == CW'(1)) begin
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Gated with rst_n so upstream never sees ready while the block is held in reset.
  assign in_ready  = rst_n & (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign quotient  = r_work;
  assign remainder = r_rem;
  assign div_zero  = r_dz;

`ifdef KARDIV_CHECK_EN
  logic [N-1:0] r_chk;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_chk <= '0;
    end else if (r_state == S_IDLE && in_valid) begin
      r_chk <= chk_factor;
    end
  end

  assign mismatch = (r_state == S_DONE) &
                    ((r_work != {{N{1'b0}}, r_chk}) | (r_rem != '0) | r_dz);
`endif

endmodule
